// File: rtl/l1_arbiter.sv
// Two-client arbiter that serialises L1I line reads and L1D reads/writebacks
// onto one registered L2 port, alternating grants when both clients contend.
module l1_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic         l2_read,
  output logic         l2_write,
  output logic [31:0]  l2_address,
  output logic [255:0] l2_wdata,
  input  logic [255:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  state_t       state;
  logic         last_grant;   // 0 = I won last, 1 = D won last
  logic [255:0] rdata_reg;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  // On a tie the client that did not win last time gets the port.
  assign pick_d = d_req & (~i_req | ~last_grant);

  assign i_pmem_rdata = rdata_reg;
  assign d_pmem_rdata = rdata_reg;

  // NOTE: every register here is assigned with <= so that all state updates
  // see the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      rdata_reg   <= '0;
      l2_address  <= '0;
      l2_wdata    <= '0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      i_pmem_resp <= 1'b0;
      d_pmem_resp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            if (pick_d) begin
              state      <= SERVE_D;
              last_grant <= 1'b1;
              l2_address <= d_pmem_address;
              l2_wdata   <= d_pmem_wdata;
              // Writeback wins over a simultaneous read from the same client.
              l2_write   <= d_pmem_write;
              l2_read    <= ~d_pmem_write;
            end else begin
              state      <= SERVE_I;
              last_grant <= 1'b0;
              l2_address <= i_pmem_address;
              l2_read    <= 1'b1;
              l2_write   <= 1'b0;
            end
          end
        end

        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            rdata_reg   <= l2_rdata;
            l2_read     <= 1'b0;
            l2_write    <= 1'b0;
            i_pmem_resp <= (state == SERVE_I);
            d_pmem_resp <= (state == SERVE_D);
            state       <= DONE;
          end
        end

        DONE: begin
          // The idle cycle that follows lets the served client drop its request.
          i_pmem_resp <= 1'b0;
          d_pmem_resp <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_arbiter.sv
// Self-checking bench for l1_arbiter: table of request vectors plus hand-written
// reset, fairness and spurious-response sequences, scored through a queue.
module tb_l1_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;

  always #5 clk = ~clk;

  l1_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_rdata       (l2_rdata),
    .l2_resp        (l2_resp)
  );

  typedef struct {
    bit          d;
    bit          wr;
    logic [31:0] addr;
    logic [255:0] wdata;
  } txn_t;

  typedef struct {
    bit           i_rd;
    bit           d_rd;
    bit           d_wr;
    logic [31:0]  i_addr;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    int           delay;
    logic [255:0] rdata;
    bit           exp_d_first;
  } vec_t;

  txn_t         sb[$];
  logic [255:0] last_rd;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst            = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    l2_resp        = 1'b0;
    l2_rdata       = '0;
    tick();
    rst = 1'b0;
    sb.delete();
    last_rd = '0;
    check("rst_ctl", {l2_read, l2_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    check("rst_addr", l2_address, 32'h0);
    check("rst_wdata", l2_wdata, 256'h0);
    check("rst_rdata", d_pmem_rdata, 256'h0);
  endtask

  // Waits for the next L2 request, checks it against the scoreboard head,
  // answers after `delay` request cycles and checks the client response.
  task automatic serve_one(input int delay, input logic [255:0] rd, output int waited);
    txn_t         e;
    logic [255:0] exp_rd;
    waited = 0;
    while (!(l2_read || l2_write) && waited < 40) begin
      tick();
      waited++;
    end
    if (!(l2_read || l2_write)) begin
      check("l2_req_timeout", 1'b0, 1'b1);
      if (sb.size() > 0) sb.delete(0);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    check("l2_address", l2_address, e.addr);
    check("l2_op", {l2_read, l2_write}, {~e.wr, e.wr});
    if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
    exp_rd = e.wr ? last_rd : rd;
    for (int c = 1; c < delay; c++) begin
      if (e.d) begin
        d_pmem_address = $urandom;
        d_pmem_wdata   = {8{$urandom}};
      end else begin
        i_pmem_address = $urandom;
      end
      tick();
      check("hold", {l2_read, l2_write, l2_address, i_pmem_resp, d_pmem_resp},
            {~e.wr, e.wr, e.addr, 2'b00});
      if (e.wr) check("hold_wdata", l2_wdata, e.wdata);
    end
    l2_resp  = 1'b1;
    l2_rdata = exp_rd;
    tick();
    l2_resp  = 1'b0;
    l2_rdata = {8{$urandom}};
    check("resp", {i_pmem_resp, d_pmem_resp}, {~e.d, e.d});
    check("resp_rdata", e.d ? d_pmem_rdata : i_pmem_rdata, exp_rd);
    check("l2_drop", {l2_read, l2_write}, 2'b00);
    last_rd = exp_rd;
    if (e.d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
    tick();
    check("resp_pulse", {i_pmem_resp, d_pmem_resp, l2_read, l2_write}, 4'b0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    txn_t ti;
    txn_t td;
    int   w;
    int   n;

    vecs[0] = '{1, 0, 0, 32'h0000_1240, 32'h0, '0, 5, {32{8'hA5}}, 0};
    vecs[1] = '{0, 1, 1, 32'h0, 32'h8000_00E0, {8{32'hDEADBEEF}}, 3, '0, 1};
    vecs[2] = '{0, 1, 0, 32'h0, 32'h0000_0400, '0, 1, {8{32'h1234_5678}}, 1};
    vecs[3] = '{1, 0, 1, 32'h0000_2000, 32'h0000_3000, {8{32'hCAFE_F00D}}, 2,
                {4{64'h0123_4567_89AB_CDEF}}, 0};
    vecs[4] = '{1, 0, 0, 32'h0000_6000, 32'h0, '0, 2, {16{16'h5A3C}}, 0};
    vecs[5] = '{1, 1, 0, 32'h0000_7000, 32'h0000_7800, '0, 3, {8{32'h0F0F_1234}}, 1};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      i_pmem_read    = vecs[i].i_rd;
      i_pmem_address = vecs[i].i_addr;
      d_pmem_read    = vecs[i].d_rd;
      d_pmem_write   = vecs[i].d_wr;
      d_pmem_address = vecs[i].d_addr;
      d_pmem_wdata   = vecs[i].d_wdata;
      ti = '{0, 0, vecs[i].i_addr, '0};
      td = '{1, vecs[i].d_wr, vecs[i].d_addr, vecs[i].d_wdata};
      if (vecs[i].i_rd && (vecs[i].d_rd || vecs[i].d_wr)) begin
        if (vecs[i].exp_d_first) begin
          sb.push_back(td);
          sb.push_back(ti);
        end else begin
          sb.push_back(ti);
          sb.push_back(td);
        end
        n = 2;
      end else begin
        if (vecs[i].i_rd) sb.push_back(ti);
        else              sb.push_back(td);
        n = 1;
      end
      for (int k = 0; k < n; k++) begin
        serve_one(vecs[i].delay, (k == 0) ? vecs[i].rdata : ~vecs[i].rdata, w);
        check("grant_latency", 32'(w), 32'd1);
      end
    end

    // Simultaneous requests straight out of reset: I wins, then D.
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0100;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0200;
    sb.push_back('{0, 0, 32'h0000_0100, '0});
    sb.push_back('{1, 0, 32'h0000_0200, '0});
    serve_one(1, {8{32'h1111_2222}}, w);
    check("tie_latency", 32'(w), 32'd1);
    serve_one(1, {8{32'h3333_4444}}, w);
    check("tie_gap", 32'(w), 32'd1);

    // Fairness: both clients keep re-requesting; grants must alternate.
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1000;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_2000;
    sb.push_back('{0, 0, 32'h0000_1000, '0});
    sb.push_back('{1, 0, 32'h0000_2000, '0});
    for (int r = 0; r < 6; r++) begin
      bit served_d;
      logic [31:0] a;
      served_d = (sb.size() > 0) ? sb[0].d : 1'b0;
      serve_one(2, {8{32'h0000_0100 + 32'(r)}}, w);
      check("fair_latency", 32'(w), 32'd1);
      if (r < 4) begin
        if (served_d) begin
          a = 32'h0000_2000 + 32'(r + 1) * 32'h20;
          d_pmem_read    = 1'b1;
          d_pmem_address = a;
          sb.push_back('{1, 0, a, '0});
        end else begin
          a = 32'h0000_1000 + 32'(r + 1) * 32'h20;
          i_pmem_read    = 1'b1;
          i_pmem_address = a;
          sb.push_back('{0, 0, a, '0});
        end
      end
    end

    // Reset while SERVE_D is in flight: aborted with no response.
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_9000;
    tick();
    check("mid_serve_d", {l2_read, l2_write, l2_address}, {2'b10, 32'h0000_9000});
    tick();
    rst            = 1'b1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_A000;
    tick();
    check("abort_ctl", {l2_read, l2_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    check("abort_rdata", i_pmem_rdata, 256'h0);
    rst = 1'b0;
    sb.delete();
    last_rd = '0;
    sb.push_back('{0, 0, 32'h0000_A000, '0});
    sb.push_back('{1, 0, 32'h0000_9000, '0});
    serve_one(2, {8{32'h5555_6666}}, w);
    check("post_rst_latency", 32'(w), 32'd1);
    serve_one(2, {8{32'h7777_8888}}, w);
    check("post_rst_gap", 32'(w), 32'd1);

    // Spurious L2 response while idle must be ignored.
    l2_resp  = 1'b1;
    l2_rdata = '1;
    tick();
    l2_resp  = 1'b0;
    check("spurious_ctl", {l2_read, l2_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    tick();
    check("spurious_ctl2", {l2_read, l2_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    check("spurious_rdata", d_pmem_rdata, last_rd);
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_C000;
    d_pmem_wdata   = {8{32'h600D_F00D}};
    sb.push_back('{1, 1, 32'h0000_C000, {8{32'h600D_F00D}}});
    serve_one(2, '0, w);
    check("spurious_wr_latency", 32'(w), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
